// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: special scan codes,
// frame length and bit-counter encoding.
package ps2_pkg;

    localparam logic [7:0]  PS2_BREAK      = 8'hF0;
    localparam logic [7:0]  PS2_EXT        = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam int unsigned BIT_CNT_W      = 4;
    localparam logic [BIT_CNT_W-1:0] BIT_IDLE       = 4'd0;
    localparam logic [BIT_CNT_W-1:0] BIT_DATA_FIRST = 4'd1;
    localparam logic [BIT_CNT_W-1:0] BIT_DATA_LAST  = 4'd8;
    localparam logic [BIT_CNT_W-1:0] BIT_PARITY     = 4'd9;
    localparam logic [BIT_CNT_W-1:0] BIT_STOP       = BIT_CNT_W'(PS2_FRAME_BITS - 1);

    // Good frame: stop bit high and odd parity over data plus parity bit.
    function automatic logic frame_ok(input logic [7:0] d, input logic par, input logic stop);
        return stop & (^d ^ par);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous circular FIFO with wrap-bit pointers; head is the entry at
// the read pointer and a pop frees space for a same-cycle push.
module ps2_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        head     = mem_q[rd_ptr_q[AW-1:0]];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchronizers, frame bit counter with timeout,
// scan-code FIFO and make/break key tracking.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err,
    output logic       key_down,
    output logic [7:0] key_code,
    output logic [7:0] press_cnt
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [2:0]           clk_sync_q, clk_sync_d;
    logic [1:0]           dat_sync_q, dat_sync_d;
    logic                 fall_q, fall_d;
    logic                 bit_q, bit_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;
    logic                 key_down_q, key_down_d;
    logic [7:0]           key_code_q, key_code_d;
    logic [7:0]           press_cnt_q, press_cnt_d;
    logic                 brk_q, brk_d;
    logic                 push_c;
    logic                 pop_c;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Sampled bit and falling-edge strobe are registered, giving the
    // 2 sync + 1 edge + 1 update latency to the outputs.
    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        fall_d     = clk_sync_q[2] & ~clk_sync_q[1];
        bit_d      = dat_sync_q[1];
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;
        if (fall_q) begin
            tmo_d = '0;
            if (bit_cnt_q == BIT_IDLE) begin
                if (!bit_q) begin
                    bit_cnt_d = BIT_DATA_FIRST;
                end
            end else if (bit_cnt_q <= BIT_DATA_LAST) begin
                shift_d   = {bit_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end else if (bit_cnt_q == BIT_PARITY) begin
                parity_d  = bit_q;
                bit_cnt_d = BIT_STOP;
            end else begin
                bit_cnt_d = BIT_IDLE;
                if (frame_ok(shift_q, parity_q, bit_q)) begin
                    push_c = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end else if (bit_cnt_q != BIT_IDLE) begin
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                frame_err_d = 1'b1;
                bit_cnt_d   = BIT_IDLE;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // Key tracking sees every good byte, even ones the FIFO has to drop.
    always_comb begin
        pop_c       = rd_en & ~fifo_empty;
        overflow_d  = overflow_q;
        key_down_d  = key_down_q;
        key_code_d  = key_code_q;
        press_cnt_d = press_cnt_q;
        brk_d       = brk_q;
        if (pop_c) begin
            overflow_d = 1'b0;
        end else if (push_c && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (push_c) begin
            if (shift_q == PS2_EXT) begin
                brk_d = brk_q;
            end else if (shift_q == PS2_BREAK) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                if (shift_q == key_code_q) begin
                    key_down_d = 1'b0;
                end
                brk_d = 1'b0;
            end else if (!key_down_q || shift_q != key_code_q) begin
                press_cnt_d = press_cnt_q + 8'd1;
                key_down_d  = 1'b1;
                key_code_d  = shift_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            dat_sync_q  <= 2'b11;
            fall_q      <= 1'b0;
            bit_q       <= 1'b1;
            bit_cnt_q   <= BIT_IDLE;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            key_down_q  <= 1'b0;
            key_code_q  <= 8'h00;
            press_cnt_q <= 8'h00;
            brk_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            fall_q      <= fall_d;
            bit_q       <= bit_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            key_down_q  <= key_down_d;
            key_code_q  <= key_code_d;
            press_cnt_q <= press_cnt_d;
            brk_q       <= brk_d;
        end
    end

    ps2_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (shift_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (data)
    );

    assign valid     = ~fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign key_down  = key_down_q;
    assign key_code  = key_code_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: directed PS/2 frames, expected bytes queued
// at issue and compared by a popping monitor.
module tb_ps2_kbd_rx;

    localparam int unsigned TMO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       overflow;
    logic       frame_err;
    logic       key_down;
    logic [7:0] key_code;
    logic [7:0] press_cnt;

    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    bit         pop_en = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FIFO_DEPTH (8),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data      (data),
        .valid     (valid),
        .overflow  (overflow),
        .frame_err (frame_err),
        .key_down  (key_down),
        .key_code  (key_code),
        .press_cnt (press_cnt)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops whenever enabled and data is presented, compares against queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (pop_en && valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_extra: got %h expected nothing", data);
                end else begin
                    check("fifo_data", 16'(data), 16'(exp_q.pop_front()));
                end
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    end

    // Error pulse monitor: counts pulses and requires each to last one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                err_seen++;
                @(negedge clk);
                check("frame_err_width", 16'(frame_err), 16'h0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"},     16'(valid),     16'h0);
        check({tag, "_overflow"},  16'(overflow),  16'h0);
        check({tag, "_frame_err"}, 16'(frame_err), 16'h0);
        check({tag, "_key_down"},  16'(key_down),  16'h0);
        check({tag, "_key_code"},  16'(key_code),  16'h0);
        check({tag, "_press_cnt"}, 16'(press_cnt), 16'h0);
        check({tag, "_data"},      16'(data),      16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Sends the first nbits of a frame; lat_chk verifies the stop-edge latency.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits, input bit lat_chk);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            if (lat_chk && i == 10) begin
                repeat (3) @(posedge clk);
                #1;
                check("lat3_valid", 16'(valid), 16'h0);
                @(posedge clk);
                #1;
                check("lat4_valid", 16'(valid), 16'h1);
                check("lat4_data", 16'(data), 16'(b));
                check("lat4_key_down", 16'(key_down), 16'h1);
                check("lat4_key_code", 16'(key_code), 16'(b));
                check("lat4_press_cnt", 16'(press_cnt), 16'h1);
                @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        pop_en = 1'b1;
        while ((exp_q.size() != 0 || valid === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        pop_en = 1'b0;
        check("drain_left", 16'(exp_q.size()), 16'h0);
        check("drain_valid", 16'(valid), 16'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq [9];
        int         e0;
        seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single make code with exact output latency.
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 11, 1'b1);
        drain();

        // Typematic repeat, then break releases the key.
        do_reset();
        exp_q.push_back(8'h1C);
        exp_q.push_back(8'h1C);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        check("rep_press_cnt", 16'(press_cnt), 16'h1);
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        check("brk_key_down", 16'(key_down), 16'h1);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        check("rel_key_down", 16'(key_down), 16'h0);
        check("rel_press_cnt", 16'(press_cnt), 16'h1);
        check("rel_key_code", 16'(key_code), 16'h1C);
        drain();

        // Bad parity.
        do_reset();
        e0 = err_seen;
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        check("par_err_cnt", 16'(err_seen - e0), 16'h1);
        check("par_valid", 16'(valid), 16'h0);
        check("par_press_cnt", 16'(press_cnt), 16'h0);
        check("par_key_down", 16'(key_down), 16'h0);

        // Overflow: ninth byte dropped but still tracked.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(seq[i]);
            send_frame(seq[i], 1'b0, 11, 1'b0);
        end
        check("ovf_set", 16'(overflow), 16'h1);
        check("ovf_press_cnt", 16'(press_cnt), 16'h9);
        check("ovf_key_code", 16'(key_code), 16'h44);
        drain();
        check("ovf_clear", 16'(overflow), 16'h0);

        // Timeout on a partial frame, then a clean frame.
        do_reset();
        e0 = err_seen;
        send_frame(8'h2A, 1'b0, 5, 1'b0);
        repeat (TMO + 20) @(negedge clk);
        check("tmo_err_cnt", 16'(err_seen - e0), 16'h1);
        check("tmo_valid", 16'(valid), 16'h0);
        exp_q.push_back(8'h2A);
        send_frame(8'h2A, 1'b0, 11, 1'b0);
        check("tmo_key_code", 16'(key_code), 16'h2A);
        check("tmo_press_cnt", 16'(press_cnt), 16'h1);
        drain();
        check("tmo_err_total", 16'(err_seen - e0), 16'h1);

        // Reset mid-frame with buffered entries.
        do_reset();
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h1D);
        send_frame(8'h15, 1'b0, 11, 1'b0);
        send_frame(8'h1D, 1'b0, 11, 1'b0);
        drain();
        send_frame(8'h24, 1'b0, 11, 1'b0);
        send_frame(8'h2D, 1'b0, 11, 1'b0);
        send_frame(8'h2C, 1'b0, 11, 1'b0);
        check("pre_rst_press_cnt", 16'(press_cnt), 16'h5);
        check("pre_rst_valid", 16'(valid), 16'h1);
        e0 = err_seen;
        send_frame(8'h35, 1'b0, 4, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("mid");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        check("post_rst_press_cnt", 16'(press_cnt), 16'h1);
        check("post_rst_key_code", 16'(key_code), 16'h1C);
        drain();
        repeat (TMO + 20) @(negedge clk);
        check("post_rst_err_cnt", 16'(err_seen - e0), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
